opendrain_bit_driver: RTL and testbench

OPENDRAIN_BIT_DRIVER -- requirements
Module: opendrain_bit_driver

---
 rtl/lattice_ice40_pkg.sv | 11 +
 rtl/opendrain_bit_driver_io.sv | 28 ++
 rtl/opendrain_bit_driver.sv | 107 ++++++++++
 tb/tb_opendrain_bit_driver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lattice_ice40_pkg.sv
// Shared iCE40 definitions: driver FSM state encodings and the open-drain pad configuration.
package lattice_ice40_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    // Tristate output without output register, plain unregistered input.
    localparam logic [5:0] SB_IO_PIN_TYPE_OD = 6'b1010_01;

endpackage

// File: rtl/opendrain_bit_driver_io.sv
// Open-drain pad wrapper: SB_IO with the internal pull-up in synthesis, equivalent tristate model otherwise.
// Latency: none, d_in follows the pin combinationally. Backpressure: none.
module opendrain_io
    import lattice_ice40_pkg::*;
(
    inout  wire  pin,
    input  logic oe,
    input  logic d_out,
    output logic d_in
);

`ifdef SYNTHESIS
    SB_IO #(
        .PIN_TYPE (SB_IO_PIN_TYPE_OD),
        .PULLUP   (1'b1)
    ) u_sb_io (
        .PACKAGE_PIN   (pin),
        .OUTPUT_ENABLE (oe),
        .D_OUT_0       (d_out),
        .D_IN_0        (d_in)
    );
`else
    pullup (pin);
    assign pin  = oe ? d_out : 1'bz;
    assign d_in = pin;
`endif

endmodule

// File: rtl/opendrain_bit_driver.sv
// Open-drain single-bit driver: holds each bit on the pin for a fixed window, then reports the read-back level.
// Latency: done at accept+HOLD_CYCLES+1 (+2 more with OPENDRAIN_READBACK_SYNC_EN). Backpressure: tx_ready low during DRIVE.
// Optional macro OPENDRAIN_READBACK_SYNC_EN inserts a 2-flop synchronizer on the read-back path.
module opendrain_bit_driver
    import lattice_ice40_pkg::*;
#(
    parameter int HOLD_CYCLES = 8
)
(
    input  logic clk,
    input  logic rst_n,
    inout  wire  pin,
    input  logic tx_valid,
    input  logic tx_bit,
    output logic tx_ready,
    output logic done,
    output logic rx_bit,
    output logic mismatch,
    output logic pin_level
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 3);
`ifdef OPENDRAIN_READBACK_SYNC_EN
    localparam int DRIVE_LEN = HOLD_CYCLES + 2;
`else
    localparam int DRIVE_LEN = HOLD_CYCLES;
`endif
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRIVE_LEN - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             bit_q;
    logic             oe;
    logic             d_in;
    logic             rb;
    logic             accept;

    opendrain_io u_io (
        .pin   (pin),
        .oe    (oe),
        .d_out (1'b0),
        .d_in  (d_in)
    );

    assign pin_level = d_in;
    assign tx_ready  = (state != ST_DRIVE);
    assign accept    = tx_valid & tx_ready;

`ifdef OPENDRAIN_READBACK_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_in};
        end
    end

    assign rb = sync_q[1];
`else
    assign rb = d_in;
`endif

    // The window counter reaches zero in the last DRIVE cycle; the read-back is captured on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_q    <= 1'b1;
            oe       <= 1'b0;
            done     <= 1'b0;
            rx_bit   <= 1'b1;
            mismatch <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_REPORT: begin
                    if (accept) begin
                        state <= ST_DRIVE;
                        cnt   <= CNT_LOAD;
                        bit_q <= tx_bit;
                        oe    <= ~tx_bit;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == '0) begin
                        state    <= ST_REPORT;
                        oe       <= 1'b0;
                        done     <= 1'b1;
                        rx_bit   <= rb;
                        mismatch <= rb ^ bit_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    oe    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opendrain_bit_driver.sv
// Bench for opendrain_bit_driver: directed scenarios plus randomized bits/contention against a window-level model.
module tb_opendrain_bit_driver;

    localparam int HOLD = 8;
`ifdef OPENDRAIN_READBACK_SYNC_EN
    localparam int LAT = HOLD + 2;
`else
    localparam int LAT = HOLD;
`endif

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic tx_valid = 1'b0;
    logic tx_bit   = 1'b0;
    logic tb_pull  = 1'b0;
    wire  pin;
    logic tx_ready, done, rx_bit, mismatch, pin_level;

    int n_cmp = 0;
    int n_err = 0;

    assign pin = tb_pull ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    opendrain_bit_driver #(.HOLD_CYCLES(HOLD)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin       (pin),
        .tx_valid  (tx_valid),
        .tx_bit    (tx_bit),
        .tx_ready  (tx_ready),
        .done      (done),
        .rx_bit    (rx_bit),
        .mismatch  (mismatch),
        .pin_level (pin_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (rx_bit !== 1'b1) begin n_err++; $display("FAIL reset_rx_bit got=%b exp=1", rx_bit); end
        n_cmp++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL reset_mismatch got=%b exp=0", mismatch); end
        n_cmp++; if (pin_level !== 1'b1) begin n_err++; $display("FAIL reset_pin got=%b exp=1", pin_level); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_tx_ready got=%b exp=1", tx_ready); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL post_reset_done got=%b exp=0", done); end
        n_cmp++; if (pin_level !== 1'b1) begin n_err++; $display("FAIL post_reset_pin got=%b exp=1", pin_level); end
    endtask

    task automatic test_send0();
        tx_bit   = 1'b0;
        tx_valid = 1'b1;
        n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL send0_ready got=%b exp=1", tx_ready); end
        tick();
        for (int k = 1; k <= LAT; k++) begin
            tx_valid = (k == LAT) ? 1'b0 : 1'($urandom_range(0, 1));
            tx_bit   = 1'($urandom_range(0, 1));
            n_cmp++; if (pin_level !== 1'b0) begin n_err++; $display("FAIL send0_pin cyc=N+%0d got=%b exp=0", k, pin_level); end
            n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL send0_busy cyc=N+%0d got=%b exp=0", k, tx_ready); end
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL send0_early_done cyc=N+%0d got=%b exp=0", k, done); end
            tick();
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL send0_done got=%b exp=1", done); end
        n_cmp++; if (rx_bit !== 1'b0) begin n_err++; $display("FAIL send0_rx_bit got=%b exp=0", rx_bit); end
        n_cmp++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL send0_mismatch got=%b exp=0", mismatch); end
        n_cmp++; if (pin_level !== 1'b1) begin n_err++; $display("FAIL send0_report_pin got=%b exp=1", pin_level); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL send0_done_width got=%b exp=0", done); end
        n_cmp++; if (rx_bit !== 1'b0) begin n_err++; $display("FAIL send0_rx_hold got=%b exp=0", rx_bit); end
    endtask

    task automatic test_contention();
        tx_bit   = 1'b1;
        tx_valid = 1'b1;
        tb_pull  = 1'b1;
        #1;
        n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL cont_ready got=%b exp=1", tx_ready); end
        tick();
        tx_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            n_cmp++; if (u_dut.oe !== 1'b0) begin n_err++; $display("FAIL cont_dut_drives cyc=N+%0d got=%b exp=0", k, u_dut.oe); end
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL cont_early_done cyc=N+%0d got=%b exp=0", k, done); end
            tick();
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL cont_done got=%b exp=1", done); end
        n_cmp++; if (rx_bit !== 1'b0) begin n_err++; $display("FAIL cont_rx_bit got=%b exp=0", rx_bit); end
        n_cmp++; if (mismatch !== 1'b1) begin n_err++; $display("FAIL cont_mismatch got=%b exp=1", mismatch); end
        tb_pull = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        tx_bit   = 1'b0;
        tx_valid = 1'b1;
        n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b exp=1", tx_ready); end
        for (int c = 1; c <= 2 * LAT + 2; c++) begin
            tick();
            if (c == LAT + 2) tx_valid = 1'b0;
            if (c == LAT + 1 || c == 2 * LAT + 2) begin
                n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done cyc=N+%0d got=%b exp=1", c, done); end
                n_cmp++; if (pin_level !== 1'b1) begin n_err++; $display("FAIL b2b_gap_pin cyc=N+%0d got=%b exp=1", c, pin_level); end
                n_cmp++; if (rx_bit !== 1'b0) begin n_err++; $display("FAIL b2b_rx cyc=N+%0d got=%b exp=0", c, rx_bit); end
            end else begin
                n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_nodone cyc=N+%0d got=%b exp=0", c, done); end
                n_cmp++; if (pin_level !== 1'b0) begin n_err++; $display("FAIL b2b_pin cyc=N+%0d got=%b exp=0", c, pin_level); end
            end
        end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_tail_done got=%b exp=0", done); end
    endtask

    task automatic test_reset_mid_drive();
        tx_bit   = 1'b0;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (pin_level !== 1'b0) begin n_err++; $display("FAIL abort_pre_pin got=%b exp=0", pin_level); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pin_level !== 1'b1) begin n_err++; $display("FAIL abort_pin_release got=%b exp=1", pin_level); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got=%b exp=1", tx_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < LAT + 3; c++) begin
            tick();
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_spurious_done cyc=%0d got=%b exp=0", c, done); end
            n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready_after cyc=%0d got=%b exp=1", c, tx_ready); end
            n_cmp++; if (pin_level !== 1'b1) begin n_err++; $display("FAIL abort_pin_after cyc=%0d got=%b exp=1", c, pin_level); end
        end
    endtask

    task automatic test_random();
        logic b, p, exp_pin;
        int   gap;
        for (int t = 0; t < 24; t++) begin
            b   = 1'($urandom_range(0, 1));
            p   = ($urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 2);
            // Model: the pin reads low whenever anyone pulls it low; readback is that level.
            exp_pin = b & ~p;
            for (int g = 0; g < gap; g++) begin
                tx_valid = 1'b0;
                tick();
                n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rnd_idle_done t=%0d got=%b exp=0", t, done); end
            end
            tx_bit   = b;
            tx_valid = 1'b1;
            tb_pull  = p;
            #1;
            n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL rnd_ready t=%0d got=%b exp=1", t, tx_ready); end
            tick();
            for (int k = 1; k <= LAT; k++) begin
                tx_valid = (k == LAT) ? 1'b0 : 1'($urandom_range(0, 1));
                tx_bit   = 1'($urandom_range(0, 1));
                n_cmp++; if (pin_level !== exp_pin) begin n_err++; $display("FAIL rnd_pin t=%0d cyc=N+%0d got=%b exp=%b", t, k, pin_level, exp_pin); end
                n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL rnd_busy t=%0d cyc=N+%0d got=%b exp=0", t, k, tx_ready); end
                tick();
            end
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rnd_done t=%0d got=%b exp=1", t, done); end
            n_cmp++; if (rx_bit !== exp_pin) begin n_err++; $display("FAIL rnd_rx t=%0d got=%b exp=%b", t, rx_bit, exp_pin); end
            n_cmp++; if (mismatch !== (exp_pin != b)) begin n_err++; $display("FAIL rnd_mismatch t=%0d got=%b exp=%b", t, mismatch, exp_pin != b); end
            tb_pull = 1'b0;
            #1;
            n_cmp++; if (pin_level !== 1'b1) begin n_err++; $display("FAIL rnd_release t=%0d got=%b exp=1", t, pin_level); end
        end
        tx_valid = 1'b0;
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rnd_tail_done got=%b exp=0", done); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_send0();
        test_contention();
        test_back_to_back();
        test_reset_mid_drive();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
